// File: rtl/serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl_if
//  Description : Requester <-> serial adder controller bundle. The requester
//                (master) issues start with operands a/b; the controller
//                (slave) reports busy, a one-cycle done pulse and the
//                registered sum/cout.
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Requester side: drives the request and operands, observes the result
  modport master (
    output start, a, b,
    input  busy, done, sum, cout
  );

  // Controller side: consumes the request and operands, drives the result
  modport slave (
    input  start, a, b,
    output busy, done, sum, cout
  );
endinterface
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl
//  Description : Bit-serial adder controller. Adds two WIDTH-bit operands
//                LSB-first through a single 1-bit full-adder cell (two half
//                adders plus an OR) over WIDTH clock cycles. Captures the
//                operands on an accepted start, sequences the operand shift
//                registers, carry register and partial-sum register, and
//                publishes sum/cout with a one-cycle done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  serial_add_ctrl_if.slave  bus
);

  // Bit counter only has to reach WIDTH-1; keep at least one bit for WIDTH=2.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_last_cnt = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q,  a_sh_d;
  logic [WIDTH-1:0] b_sh_q,  b_sh_d;
  logic [WIDTH-1:0] p_sh_q,  p_sh_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             c_q,     c_d;
  logic             cout_q,  cout_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic [CW-1:0]    cnt_q,   cnt_d;

  // Full-adder cell built from two half adders; the two carries never
  // assert together, so a plain OR merges them.
  logic w_ha0_s, w_ha0_c;
  logic w_ha1_s, w_ha1_c;
  logic w_s, w_co;

  halfadd u_ha0 (
    .i_a (a_sh_q[0]),
    .i_b (b_sh_q[0]),
    .o_s (w_ha0_s),
    .o_c (w_ha0_c)
  );

  halfadd u_ha1 (
    .i_a (w_ha0_s),
    .i_b (c_q),
    .o_s (w_ha1_s),
    .o_c (w_ha1_c)
  );

  assign w_s  = w_ha1_s;
  assign w_co = w_ha0_c | w_ha1_c;

  // Next-state, datapath sequencing and registered-output decode
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    p_sh_d  = p_sh_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // One bit per edge: new sum bit enters at the MSB so that after
        // WIDTH edges the LSB computed first has shifted down to bit 0.
        p_sh_d = {w_s, p_sh_q[WIDTH-1:1]};
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        c_d    = w_co;
        if (cnt_q == c_last_cnt) begin
          sum_d   = {w_s, p_sh_q[WIDTH-1:1]};
          cout_d  = w_co;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DONE: begin
        // A start seen while done is high chains straight into a new add,
        // giving one result every WIDTH+1 cycles.
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are decoded from the next state so they are registered
    // and line up with the state they describe.
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers; asynchronous reset aborts any add in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      p_sh_q  <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      p_sh_q  <= p_sh_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// ============================================================================
//  Module      : halfadd
//  Description : 1-bit half adder used to build the serial full-adder cell.
//  Revision    : 1.0  initial release
// ============================================================================
module halfadd (
  input  wire logic i_a,
  input  wire logic i_b,
  output logic      o_s,
  output logic      o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_add_ctrl
//  Description : Scoreboard bench for serial_add_ctrl (WIDTH=8). Stimulus
//                pushes the expected {cout,sum} on issue; a monitor pops and
//                compares on every done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  logic [WIDTH:0]   sb[$];
  logic [WIDTH-1:0] last_sum;
  logic             last_cout;

  // Single comparison point: counts every check, reports each failure
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each done pulse; also flags any change
  // of sum/cout outside a done pulse.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_sum  = '0;
      last_cout = 1'b0;
    end else if (bus.done) begin
      n_done++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got {cout,sum}=0x%0h, expected no done pulse", {bus.cout, bus.sum});
      end else begin
        check("result", {23'd0, bus.cout, bus.sum}, {23'd0, sb.pop_front()});
      end
      last_sum  = bus.sum;
      last_cout = bus.cout;
    end else if (bus.sum !== last_sum || bus.cout !== last_cout) begin
      n_fail++;
      $display("FAIL sum_stable: got {cout,sum}=0x%0h, expected held 0x%0h", {bus.cout, bus.sum}, {last_cout, last_sum});
    end
  end

  // Bounded wait for done; returns negedges elapsed and busy cycles seen
  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles      = 0;
    busy_cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (bus.busy) busy_cycles++;
    end while (!bus.done && cycles < 50);
    if (!bus.done) begin
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", cycles);
    end
  endtask

  // Issue one add from idle with a single-cycle start pulse
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int guard = 0;
    @(negedge clk);
    while (bus.busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    sb.push_back({1'b0, a} + {1'b0, b});
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } vec_t;

  vec_t dir_vecs[4] = '{'{8'hFF, 8'h01}, '{8'hFF, 8'hFF}, '{8'h00, 8'h00}, '{8'h80, 8'h7F}};

  initial begin
    int cyc, bcyc, d0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b0;
    #3;
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_sum",  {24'd0, bus.sum},  32'd0);
    check("reset_cout", {31'd0, bus.cout}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: basic add, latency and busy length
    bus.start = 1'b1; bus.a = 8'h35; bus.b = 8'h4A;
    sb.push_back(9'h07F);
    @(negedge clk);
    check("t1_busy_after_accept", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00;
    wait_done(cyc, bcyc);
    check("t1_latency", cyc + 1, 9);
    check("t1_busy_cycles", bcyc + 1, 8);
    check("t1_busy_in_done", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    check("t1_done_one_cycle", {31'd0, bus.done}, 32'd0);

    // 2: carry-out boundaries and zero/mixed operands
    foreach (dir_vecs[i]) begin
      issue(dir_vecs[i].a, dir_vecs[i].b);
      wait_done(cyc, bcyc);
    end

    // 3: start held high, operands changed mid-RUN, back-to-back results
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20;
    sb.push_back(9'h030);
    sb.push_back(9'h00C);
    sb.push_back(9'h100);
    repeat (3) @(negedge clk);
    bus.a = 8'h05; bus.b = 8'h07;
    wait_done(cyc, bcyc);
    repeat (3) @(negedge clk);
    bus.a = 8'h80; bus.b = 8'h80;
    wait_done(cyc, bcyc);
    check("t3_gap_second", cyc + 3, 9);
    @(negedge clk);
    bus.start = 1'b0;
    check("t3_busy_back_to_back", {31'd0, bus.busy}, 32'd1);
    wait_done(cyc, bcyc);
    check("t3_gap_third", cyc + 1, 9);

    // 4: asynchronous reset in the middle of a run
    @(negedge clk);
    d0 = n_done;
    bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t4_busy_cleared", {31'd0, bus.busy}, 32'd0);
    check("t4_done_cleared", {31'd0, bus.done}, 32'd0);
    check("t4_sum_cleared",  {24'd0, bus.sum},  32'd0);
    check("t4_cout_cleared", {31'd0, bus.cout}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("t4_no_done_pulse", n_done, d0);
    issue(8'h01, 8'h02);
    wait_done(cyc, bcyc);

    // 5: start pulse while busy must be ignored
    @(negedge clk);
    d0 = n_done;
    bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h34;
    sb.push_back(9'h046);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc, bcyc);
    check("t5_latency_unchanged", cyc + 4, 9);
    repeat (12) @(negedge clk);
    check("t5_single_done", n_done, d0 + 1);

    // 6: random operands with random idle gaps
    for (int i = 0; i < 200; i++) begin
      issue(WIDTH'($urandom), WIDTH'($urandom));
      wait_done(cyc, bcyc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
